ctrl_unit: RTL and testbench

CTRL_UNIT -- requirements
Module: ctrl_unit

---
 rtl/ctrl_unit_pkg.sv | 142 ++++++++++++++
 rtl/ctrl_unit_decode.sv | 42 ++++
 rtl/ctrl_unit.sv | 265 ++++++++++++++++++++++++++
 tb/tb_ctrl_unit.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_unit_pkg
// Brief    : Shared opcode/funct, state, ALU-op and mux-select encodings.
// Revision : 1.0
// ============================================================================
package ctrl_unit_pkg;

  // Opcodes
  localparam logic [5:0] c_OP_RTYPE = 6'h00;
  localparam logic [5:0] c_OP_J     = 6'h02;
  localparam logic [5:0] c_OP_JAL   = 6'h03;
  localparam logic [5:0] c_OP_BEQ   = 6'h04;
  localparam logic [5:0] c_OP_BNE   = 6'h05;
  localparam logic [5:0] c_OP_ADDI  = 6'h08;
  localparam logic [5:0] c_OP_ADDIU = 6'h09;
  localparam logic [5:0] c_OP_SLTI  = 6'h0A;
  localparam logic [5:0] c_OP_LW    = 6'h23;
  localparam logic [5:0] c_OP_SW    = 6'h2B;

  // R-type funct codes
  localparam logic [5:0] c_FN_MFHI  = 6'h10;
  localparam logic [5:0] c_FN_MFLO  = 6'h12;
  localparam logic [5:0] c_FN_MULT  = 6'h18;
  localparam logic [5:0] c_FN_DIV   = 6'h1A;
  localparam logic [5:0] c_FN_ADD   = 6'h20;
  localparam logic [5:0] c_FN_SUB   = 6'h22;

  // ALU operations
  localparam logic [2:0] c_ALU_ADD   = 3'd0;
  localparam logic [2:0] c_ALU_SUB   = 3'd1;
  localparam logic [2:0] c_ALU_AND   = 3'd2;
  localparam logic [2:0] c_ALU_OR    = 3'd3;
  localparam logic [2:0] c_ALU_SLT   = 3'd4;
  localparam logic [2:0] c_ALU_FUNCT = 3'd5;

  // PC source select
  localparam logic [1:0] c_PC_ALU    = 2'd0;
  localparam logic [1:0] c_PC_ALUOUT = 2'd1;
  localparam logic [1:0] c_PC_JUMP   = 2'd2;
  localparam logic [1:0] c_PC_EXC    = 2'd3;

  // Memory address select (iord)
  localparam logic [1:0] c_AD_PC     = 2'd0;
  localparam logic [1:0] c_AD_ALUOUT = 2'd1;
  localparam logic [1:0] c_AD_EXC    = 2'd2;

  // Register destination select
  localparam logic [1:0] c_RD_RT  = 2'd0;
  localparam logic [1:0] c_RD_RD  = 2'd1;
  localparam logic [1:0] c_RD_R31 = 2'd2;
  localparam logic [1:0] c_RD_SP  = 2'd3;

  // ALU operand selects
  localparam logic [1:0] c_SA_PC    = 2'd0;
  localparam logic [1:0] c_SA_A     = 2'd1;
  localparam logic [1:0] c_SB_B     = 2'd0;
  localparam logic [1:0] c_SB_FOUR  = 2'd1;
  localparam logic [1:0] c_SB_IMM   = 2'd2;
  localparam logic [1:0] c_SB_IMMSH = 2'd3;

  // Exception cause
  localparam logic [1:0] c_EX_OPCODE = 2'd0;
  localparam logic [1:0] c_EX_OVF    = 2'd1;
  localparam logic [1:0] c_EX_DIV0   = 2'd2;

  // Register-file write-data select
  localparam logic [2:0] c_WD_ALUOUT = 3'd0;
  localparam logic [2:0] c_WD_LAUX   = 3'd1;
  localparam logic [2:0] c_WD_PC     = 3'd2;
  localparam logic [2:0] c_WD_HI     = 3'd3;
  localparam logic [2:0] c_WD_LO     = 3'd4;
  localparam logic [2:0] c_WD_SP     = 3'd5;
  localparam logic [2:0] c_WD_LT     = 3'd6;

  // Value the datapath drives when c_WD_SP is selected
  localparam logic [31:0] c_SP_INIT = 32'd227;

  typedef enum logic [5:0] {
    S_RESET_ST    = 6'd0,
    S_FETCH       = 6'd1,
    S_IR_LOAD     = 6'd2,
    S_DECODE      = 6'd3,
    S_EXEC_R      = 6'd4,
    S_WB_R        = 6'd5,
    S_EXEC_I      = 6'd6,
    S_WB_I        = 6'd7,
    S_SLT_I       = 6'd8,
    S_ADDR        = 6'd9,
    S_MEM_RD      = 6'd10,
    S_MDR_LD      = 6'd11,
    S_WB_LD       = 6'd12,
    S_MEM_WR      = 6'd13,
    S_BRANCH      = 6'd14,
    S_JUMP        = 6'd15,
    S_JUMP_LINK   = 6'd16,
    S_MULT_START  = 6'd17,
    S_DIV_START   = 6'd18,
    S_MD_WAIT_MUL = 6'd19,
    S_MD_WAIT_DIV = 6'd20,
    S_MD_WB_MUL   = 6'd21,
    S_MD_WB_DIV   = 6'd22,
    S_MFHI        = 6'd23,
    S_MFLO        = 6'd24,
    S_EXC_OPCODE  = 6'd25,
    S_EXC_OVF     = 6'd26,
    S_EXC_DIV0    = 6'd27,
    S_EXC_PC      = 6'd28
  } state_t;

  typedef struct packed {
    logic       pcWrite;
    logic       pcWriteCond;
    logic       irWrite;
    logic       regWrite;
    logic       loadAb;
    logic       aluOutWr;
    logic       mdrWr;
    logic       epcWrite;
    logic       hiloWrite;
    logic       memRead;
    logic       memWrite;
    logic [1:0] pcSrc;
    logic [1:0] iord;
    logic [1:0] regDst;
    logic [1:0] aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] exCause;
    logic [2:0] writeData;
    logic [2:0] aluOp;
    logic       multOp;
    logic       divOp;
    logic       multDivSel;
  } ctrl_t;

  // Only the trapping add/sub raise overflow; addu/subu never do
  function automatic logic isAddSub(input logic [5:0] fn);
    return (fn == c_FN_ADD) || (fn == c_FN_SUB);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_unit_decode.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_decode
// Brief    : Opcode/funct to DECODE-successor dispatch (MULT_DIV_EN gates HI/LO ops).
// Revision : 1.0
// ============================================================================
module ctrl_decode
  import ctrl_unit_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output state_t     dispatch
);

  always_comb begin
    dispatch = S_EXC_OPCODE;
    case (opcode)
      c_OP_RTYPE: begin
        case (funct)
`ifdef MULT_DIV_EN
          c_FN_MULT: dispatch = S_MULT_START;
          c_FN_DIV:  dispatch = S_DIV_START;
          c_FN_MFHI: dispatch = S_MFHI;
          c_FN_MFLO: dispatch = S_MFLO;
`else
          c_FN_MULT, c_FN_DIV, c_FN_MFHI, c_FN_MFLO: dispatch = S_EXC_OPCODE;
`endif
          default:   dispatch = S_EXEC_R;
        endcase
      end
      c_OP_ADDI, c_OP_ADDIU: dispatch = S_EXEC_I;
      c_OP_LW, c_OP_SW:      dispatch = S_ADDR;
      c_OP_BEQ, c_OP_BNE:    dispatch = S_BRANCH;
      c_OP_J:                dispatch = S_JUMP;
      c_OP_JAL:              dispatch = S_JUMP_LINK;
      c_OP_SLTI:             dispatch = S_SLT_I;
      default:               dispatch = S_EXC_OPCODE;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_unit
// Brief    : Multicycle Moore control FSM; MULT_DIV_EN enables mult/div/mfhi/mflo.
// Revision : 1.0
// ============================================================================
module ctrl_unit
  import ctrl_unit_pkg::*;
#(
  parameter int MEM_WAIT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       lt,
  input  logic       overflow,
  input  logic       div_zero,
  input  logic       mult_done,
  input  logic       div_done,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       ir_write,
  output logic       reg_write,
  output logic       load_ab,
  output logic       alu_out_wr,
  output logic       mdr_wr,
  output logic       epc_write,
  output logic       hilo_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic [1:0] pc_src,
  output logic [1:0] iord,
  output logic [1:0] reg_dst,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] ex_cause,
  output logic [2:0] write_data,
  output logic [2:0] alu_op,
  output logic       mult_op,
  output logic       div_op,
  output logic       mult_div_sel,
  output logic [5:0] state_o
);

  localparam int c_CNT_W = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
  localparam logic [c_CNT_W-1:0] c_WAIT_LAST =
    (MEM_WAIT > 1) ? c_CNT_W'(MEM_WAIT - 1) : '0;

  state_t             r_state;
  state_t             w_nextState;
  state_t             w_dispatch;
  logic [c_CNT_W-1:0] r_waitCnt;
  logic               w_waitDone;
  ctrl_t              w_ctrl;
  ctrl_t              w_out;
  logic               w_unused;

  ctrl_decode u_decode (
    .opcode   (opcode),
    .funct    (funct),
    .dispatch (w_dispatch)
  );

  assign w_waitDone = (r_waitCnt == c_WAIT_LAST);

  // Wait counter restarts whenever the state changes, so it counts dwell time
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_RESET_ST;
      r_waitCnt <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_nextState != r_state) r_waitCnt <= '0;
      else                        r_waitCnt <= r_waitCnt + 1'b1;
    end
  end

  always_comb begin
    w_nextState = S_FETCH;
    case (r_state)
      S_RESET_ST:    w_nextState = S_FETCH;
      S_FETCH:       w_nextState = w_waitDone ? S_IR_LOAD : S_FETCH;
      S_IR_LOAD:     w_nextState = S_DECODE;
      S_DECODE:      w_nextState = w_dispatch;
      S_EXEC_R:      w_nextState = (isAddSub(funct) && overflow) ? S_EXC_OVF : S_WB_R;
      S_EXEC_I:      w_nextState = S_WB_I;
      S_ADDR:        w_nextState = (opcode == c_OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:      w_nextState = w_waitDone ? S_MDR_LD : S_MEM_RD;
      S_MDR_LD:      w_nextState = S_WB_LD;
      S_MULT_START:  w_nextState = S_MD_WAIT_MUL;
      S_DIV_START:   w_nextState = div_zero ? S_EXC_DIV0 : S_MD_WAIT_DIV;
      S_MD_WAIT_MUL: w_nextState = mult_done ? S_MD_WB_MUL : S_MD_WAIT_MUL;
      S_MD_WAIT_DIV: w_nextState = div_done ? S_MD_WB_DIV : S_MD_WAIT_DIV;
      S_EXC_OPCODE, S_EXC_OVF, S_EXC_DIV0:
                     w_nextState = w_waitDone ? S_EXC_PC : r_state;
      default:       w_nextState = S_FETCH;
    endcase
  end

  always_comb begin
    w_ctrl = '0;
    case (r_state)
      S_RESET_ST: begin
        w_ctrl.regWrite  = 1'b1;
        w_ctrl.regDst    = c_RD_SP;
        w_ctrl.writeData = c_WD_SP;
      end
      S_FETCH: begin
        w_ctrl.memRead = 1'b1;
        w_ctrl.iord    = c_AD_PC;
        w_ctrl.aluSrcA = c_SA_PC;
        w_ctrl.aluSrcB = c_SB_FOUR;
        w_ctrl.aluOp   = c_ALU_ADD;
      end
      S_IR_LOAD: begin
        w_ctrl.irWrite = 1'b1;
        w_ctrl.pcWrite = 1'b1;
        w_ctrl.pcSrc   = c_PC_ALU;
        w_ctrl.aluSrcA = c_SA_PC;
        w_ctrl.aluSrcB = c_SB_FOUR;
        w_ctrl.aluOp   = c_ALU_ADD;
      end
      S_DECODE: begin
        w_ctrl.loadAb   = 1'b1;
        w_ctrl.aluOutWr = 1'b1;
        w_ctrl.aluSrcA  = c_SA_PC;
        w_ctrl.aluSrcB  = c_SB_IMMSH;
        w_ctrl.aluOp    = c_ALU_ADD;
      end
      S_EXEC_R: begin
        w_ctrl.aluOutWr = 1'b1;
        w_ctrl.aluSrcA  = c_SA_A;
        w_ctrl.aluSrcB  = c_SB_B;
        w_ctrl.aluOp    = c_ALU_FUNCT;
      end
      S_WB_R: begin
        w_ctrl.regWrite  = 1'b1;
        w_ctrl.regDst    = c_RD_RD;
        w_ctrl.writeData = c_WD_ALUOUT;
      end
      S_EXEC_I, S_ADDR: begin
        w_ctrl.aluOutWr = 1'b1;
        w_ctrl.aluSrcA  = c_SA_A;
        w_ctrl.aluSrcB  = c_SB_IMM;
        w_ctrl.aluOp    = c_ALU_ADD;
      end
      S_WB_I: begin
        w_ctrl.regWrite  = 1'b1;
        w_ctrl.regDst    = c_RD_RT;
        w_ctrl.writeData = c_WD_ALUOUT;
      end
      // The ALU subtracts; the datapath writes back the zero-extended lt flag
      S_SLT_I: begin
        w_ctrl.aluSrcA   = c_SA_A;
        w_ctrl.aluSrcB   = c_SB_IMM;
        w_ctrl.aluOp     = c_ALU_SUB;
        w_ctrl.regWrite  = 1'b1;
        w_ctrl.regDst    = c_RD_RT;
        w_ctrl.writeData = c_WD_LT;
      end
      S_MEM_RD: begin
        w_ctrl.memRead = 1'b1;
        w_ctrl.iord    = c_AD_ALUOUT;
      end
      S_MDR_LD: w_ctrl.mdrWr = 1'b1;
      S_WB_LD: begin
        w_ctrl.regWrite  = 1'b1;
        w_ctrl.regDst    = c_RD_RT;
        w_ctrl.writeData = c_WD_LAUX;
      end
      S_MEM_WR: begin
        w_ctrl.memWrite = 1'b1;
        w_ctrl.iord     = c_AD_ALUOUT;
      end
      S_BRANCH: begin
        w_ctrl.pcWriteCond = 1'b1;
        w_ctrl.pcSrc       = c_PC_ALUOUT;
        w_ctrl.aluSrcA     = c_SA_A;
        w_ctrl.aluSrcB     = c_SB_B;
        w_ctrl.aluOp       = c_ALU_SUB;
      end
      S_JUMP: begin
        w_ctrl.pcWrite = 1'b1;
        w_ctrl.pcSrc   = c_PC_JUMP;
      end
      S_JUMP_LINK: begin
        w_ctrl.pcWrite   = 1'b1;
        w_ctrl.pcSrc     = c_PC_JUMP;
        w_ctrl.regWrite  = 1'b1;
        w_ctrl.regDst    = c_RD_R31;
        w_ctrl.writeData = c_WD_PC;
      end
      S_MULT_START: w_ctrl.multOp = 1'b1;
      S_DIV_START:  w_ctrl.divOp  = 1'b1;
      S_MD_WB_MUL:  w_ctrl.hiloWrite = 1'b1;
      S_MD_WB_DIV: begin
        w_ctrl.hiloWrite  = 1'b1;
        w_ctrl.multDivSel = 1'b1;
      end
      S_MFHI, S_MFLO: begin
        w_ctrl.regWrite  = 1'b1;
        w_ctrl.regDst    = c_RD_RD;
        w_ctrl.writeData = (r_state == S_MFHI) ? c_WD_HI : c_WD_LO;
      end
      // PC was already advanced, so PC-4 is the faulting instruction
      S_EXC_OPCODE, S_EXC_OVF, S_EXC_DIV0: begin
        w_ctrl.epcWrite = 1'b1;
        w_ctrl.memRead  = 1'b1;
        w_ctrl.iord     = c_AD_EXC;
        w_ctrl.aluSrcA  = c_SA_PC;
        w_ctrl.aluSrcB  = c_SB_FOUR;
        w_ctrl.aluOp    = c_ALU_SUB;
        w_ctrl.exCause  = (r_state == S_EXC_OVF)  ? c_EX_OVF :
                          (r_state == S_EXC_DIV0) ? c_EX_DIV0 : c_EX_OPCODE;
      end
      S_EXC_PC: begin
        w_ctrl.pcWrite = 1'b1;
        w_ctrl.pcSrc   = c_PC_EXC;
      end
      default: w_ctrl = '0;
    endcase
  end

  // Reset blanks every strobe at once, including the SP write of RESET_ST
  assign w_out = reset ? '0 : w_ctrl;

  assign pc_write      = w_out.pcWrite;
  assign pc_write_cond = w_out.pcWriteCond;
  assign ir_write      = w_out.irWrite;
  assign reg_write     = w_out.regWrite;
  assign load_ab       = w_out.loadAb;
  assign alu_out_wr    = w_out.aluOutWr;
  assign mdr_wr        = w_out.mdrWr;
  assign epc_write     = w_out.epcWrite;
  assign mem_read      = w_out.memRead;
  assign mem_write     = w_out.memWrite;
  assign pc_src        = w_out.pcSrc;
  assign iord          = w_out.iord;
  assign reg_dst       = w_out.regDst;
  assign alu_src_a     = w_out.aluSrcA;
  assign alu_src_b     = w_out.aluSrcB;
  assign ex_cause      = w_out.exCause;
  assign write_data    = w_out.writeData;
  assign alu_op        = w_out.aluOp;
  assign state_o       = r_state;

`ifdef MULT_DIV_EN
  assign mult_op      = w_out.multOp;
  assign div_op       = w_out.divOp;
  assign hilo_write   = w_out.hiloWrite;
  assign mult_div_sel = w_out.multDivSel;
  assign w_unused     = ^{zero, lt};
`else
  assign mult_op      = 1'b0;
  assign div_op       = 1'b0;
  assign hilo_write   = 1'b0;
  assign mult_div_sel = 1'b0;
  assign w_unused     = ^{zero, lt, w_out.multOp, w_out.divOp,
                          w_out.hiloWrite, w_out.multDivSel};
`endif

endmodule
`default_nettype wire

// File: tb/tb_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_ctrl_unit
// Brief    : Directed self-checking bench for ctrl_unit (MEM_WAIT = 2).
// Revision : 1.0
// ============================================================================
module tb_ctrl_unit;
  import ctrl_unit_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       zero, lt, overflow, div_zero, mult_done, div_done;
  logic       pc_write, pc_write_cond, ir_write, reg_write, load_ab, alu_out_wr;
  logic       mdr_wr, epc_write, hilo_write, mem_read, mem_write;
  logic [1:0] pc_src, iord, reg_dst, alu_src_a, alu_src_b, ex_cause;
  logic [2:0] write_data, alu_op;
  logic       mult_op, div_op, mult_div_sel;
  logic [5:0] state_o;

  int total = 0;
  int bad   = 0;

  ctrl_unit #(.MEM_WAIT(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .opcode        (opcode),
    .funct         (funct),
    .zero          (zero),
    .lt            (lt),
    .overflow      (overflow),
    .div_zero      (div_zero),
    .mult_done     (mult_done),
    .div_done      (div_done),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .ir_write      (ir_write),
    .reg_write     (reg_write),
    .load_ab       (load_ab),
    .alu_out_wr    (alu_out_wr),
    .mdr_wr        (mdr_wr),
    .epc_write     (epc_write),
    .hilo_write    (hilo_write),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .pc_src        (pc_src),
    .iord          (iord),
    .reg_dst       (reg_dst),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .ex_cause      (ex_cause),
    .write_data    (write_data),
    .alu_op        (alu_op),
    .mult_op       (mult_op),
    .div_op        (div_op),
    .mult_div_sel  (mult_div_sel),
    .state_o       (state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // From the first FETCH cycle: FETCH, FETCH, IR_LOAD, then land in DECODE
  task automatic toDecode();
    repeat (3) tick();
  endtask

  int pulses;
  int hiloEarly;

  initial begin
    reset = 1'b1; opcode = 6'h00; funct = 6'h00;
    zero = 1'b0; lt = 1'b0; overflow = 1'b0;
    div_zero = 1'b0; mult_done = 1'b0; div_done = 1'b0;

    // Reset state
    tick();
    chk("rst_state", 32'(state_o), 32'(S_RESET_ST));
    chk("rst_reg_write", 32'(reg_write), 0);
    chk("rst_mem_read", 32'(mem_read), 0);
    chk("rst_pc_write", 32'(pc_write), 0);

    // Release: SP write cycle
    reset = 1'b0;
    #1;
    chk("sp_reg_write", 32'(reg_write), 1);
    chk("sp_reg_dst", 32'(reg_dst), 32'(c_RD_SP));
    chk("sp_write_data", 32'(write_data), 32'(c_WD_SP));

    // Fetch: two mem_read cycles, then one ir_write cycle
    opcode = c_OP_RTYPE; funct = c_FN_ADD; overflow = 1'b1;
    tick();
    chk("fetch0_state", 32'(state_o), 32'(S_FETCH));
    chk("fetch0_mem_read", 32'(mem_read), 1);
    chk("fetch0_iord", 32'(iord), 32'(c_AD_PC));
    chk("fetch0_ir_write", 32'(ir_write), 0);
    tick();
    chk("fetch1_mem_read", 32'(mem_read), 1);
    chk("fetch1_ir_write", 32'(ir_write), 0);
    tick();
    chk("irload_ir_write", 32'(ir_write), 1);
    chk("irload_pc_write", 32'(pc_write), 1);
    chk("irload_mem_read", 32'(mem_read), 0);
    tick();
    chk("decode_ir_write", 32'(ir_write), 0);
    chk("decode_load_ab", 32'(load_ab), 1);

    // add with overflow -> EXC_OVF, no register write
    tick();
    chk("execr_state", 32'(state_o), 32'(S_EXEC_R));
    chk("execr_reg_write", 32'(reg_write), 0);
    tick();
    chk("ovf_state", 32'(state_o), 32'(S_EXC_OVF));
    chk("ovf_epc_write", 32'(epc_write), 1);
    chk("ovf_ex_cause", 32'(ex_cause), 32'(c_EX_OVF));
    chk("ovf_iord", 32'(iord), 32'(c_AD_EXC));
    chk("ovf_reg_write", 32'(reg_write), 0);
    tick();
    chk("ovf1_reg_write", 32'(reg_write), 0);
    chk("ovf1_mem_read", 32'(mem_read), 1);
    tick();
    chk("excpc_state", 32'(state_o), 32'(S_EXC_PC));
    chk("excpc_pc_write", 32'(pc_write), 1);
    chk("excpc_pc_src", 32'(pc_src), 32'(c_PC_EXC));
    overflow = 1'b0;
    opcode = c_OP_BEQ; zero = 1'b0;
    tick();
    chk("exc_ret_state", 32'(state_o), 32'(S_FETCH));

    // beq with zero=0: one pc_write_cond cycle, then FETCH
    toDecode();
    tick();
    chk("beq_pwc", 32'(pc_write_cond), 1);
    chk("beq_pc_src", 32'(pc_src), 32'(c_PC_ALUOUT));
    tick();
    chk("beq_pwc_off", 32'(pc_write_cond), 0);
    chk("beq_next_state", 32'(state_o), 32'(S_FETCH));

    // sw: exactly one mem_write cycle
    opcode = c_OP_SW;
    toDecode();
    tick();
    chk("sw_addr_state", 32'(state_o), 32'(S_ADDR));
    tick();
    chk("sw_mem_write", 32'(mem_write), 1);
    chk("sw_iord", 32'(iord), 32'(c_AD_ALUOUT));
    tick();
    chk("sw_mem_write_off", 32'(mem_write), 0);
    chk("sw_ret_state", 32'(state_o), 32'(S_FETCH));

    // lw full path
    opcode = c_OP_LW;
    toDecode();
    tick();
    tick();
    chk("lw_memrd0", 32'(mem_read), 1);
    tick();
    chk("lw_memrd1_state", 32'(state_o), 32'(S_MEM_RD));
    tick();
    chk("lw_mdr_wr", 32'(mdr_wr), 1);
    tick();
    chk("lw_wb_reg_write", 32'(reg_write), 1);
    chk("lw_wb_data", 32'(write_data), 32'(c_WD_LAUX));
    tick();
    chk("lw_ret_state", 32'(state_o), 32'(S_FETCH));

    // lw aborted by reset in MEM_RD
    toDecode();
    tick();
    tick();
    chk("abort_pre_state", 32'(state_o), 32'(S_MEM_RD));
    reset = 1'b1;
    #1;
    chk("abort_state", 32'(state_o), 32'(S_RESET_ST));
    chk("abort_mdr_wr", 32'(mdr_wr), 0);
    chk("abort_reg_write", 32'(reg_write), 0);
    chk("abort_mem_read", 32'(mem_read), 0);
    tick();
    chk("abort_hold_mdr_wr", 32'(mdr_wr), 0);
    chk("abort_hold_reg_write", 32'(reg_write), 0);
    reset = 1'b0;
    #1;
    chk("abort_sp_write", 32'(reg_write), 1);
    tick();
    chk("abort_fetch", 32'(state_o), 32'(S_FETCH));

    // Undefined opcode -> EXC_OPCODE, cause 0
    opcode = 6'h3F;
    toDecode();
    tick();
    chk("badop_state", 32'(state_o), 32'(S_EXC_OPCODE));
    chk("badop_epc_write", 32'(epc_write), 1);
    chk("badop_ex_cause", 32'(ex_cause), 32'(c_EX_OPCODE));
    repeat (3) tick();
    chk("badop_ret_state", 32'(state_o), 32'(S_FETCH));

    // jal: PC jump and r31 link in the same cycle
    opcode = c_OP_JAL;
    toDecode();
    tick();
    chk("jal_pc_write", 32'(pc_write), 1);
    chk("jal_pc_src", 32'(pc_src), 32'(c_PC_JUMP));
    chk("jal_reg_write", 32'(reg_write), 1);
    chk("jal_reg_dst", 32'(reg_dst), 32'(c_RD_R31));
    chk("jal_write_data", 32'(write_data), 32'(c_WD_PC));
    tick();
    chk("jal_ret_state", 32'(state_o), 32'(S_FETCH));

    // div by zero
    opcode = c_OP_RTYPE; funct = c_FN_DIV; div_zero = 1'b1;
    toDecode();
    tick();
`ifdef MULT_DIV_EN
    chk("div_op_pulse", 32'(div_op), 1);
    tick();
    chk("div0_state", 32'(state_o), 32'(S_EXC_DIV0));
    chk("div0_ex_cause", 32'(ex_cause), 32'(c_EX_DIV0));
    chk("div0_div_op_off", 32'(div_op), 0);
`else
    chk("div_off_state", 32'(state_o), 32'(S_EXC_OPCODE));
    chk("div_off_ex_cause", 32'(ex_cause), 32'(c_EX_OPCODE));
    chk("div_off_div_op", 32'(div_op), 0);
`endif
    div_zero = 1'b0;
    repeat (3) tick();
    chk("div_ret_state", 32'(state_o), 32'(S_FETCH));

    // mult
    funct = c_FN_MULT;
    toDecode();
    tick();
`ifdef MULT_DIV_EN
    chk("mult_start_state", 32'(state_o), 32'(S_MULT_START));
    pulses = mult_op ? 1 : 0;
    hiloEarly = 0;
    for (int i = 0; i < 33; i++) begin
      tick();
      if (mult_op) pulses++;
      if (hilo_write) hiloEarly++;
    end
    chk("mult_wait_state", 32'(state_o), 32'(S_MD_WAIT_MUL));
    chk("mult_hilo_early", 32'(hiloEarly), 0);
    mult_done = 1'b1;
    tick();
    mult_done = 1'b0;
    chk("mult_hilo_write", 32'(hilo_write), 1);
    chk("mult_div_sel", 32'(mult_div_sel), 0);
    chk("mult_op_pulses", 32'(pulses), 1);
    tick();
    chk("mult_hilo_off", 32'(hilo_write), 0);
    chk("mult_ret_state", 32'(state_o), 32'(S_FETCH));
`else
    chk("mult_off_state", 32'(state_o), 32'(S_EXC_OPCODE));
    chk("mult_off_mult_op", 32'(mult_op), 0);
    chk("mult_off_ex_cause", 32'(ex_cause), 32'(c_EX_OPCODE));
    repeat (3) tick();
    chk("mult_off_ret_state", 32'(state_o), 32'(S_FETCH));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
